// File: rtl/peri_bus_fabric_if.sv
// CPU-side request/ack handshake and peripheral strobe bus of the fabric.
// The slave modport is the fabric's view; the master modport drives CPU and slave returns.
interface peri_bus_fabric_if #(
  parameter int unsigned NUM_SLV = 2
);
  logic [7:0]           cpu_status;
  logic [7:0]           cpu_addr;
  logic [7:0]           cpu_wdata;
  logic                 cpu_wr_en;
  logic                 cpu_rd_en;
  logic [7:0]           cpu_rdata;
  logic                 cpu_ack;
  logic [7:0]           s_addr;
  logic [7:0]           s_wdata;
  logic [NUM_SLV-1:0]   s_wr_en;
  logic [NUM_SLV-1:0]   s_rd_en;
  logic [8*NUM_SLV-1:0] s_rdata;
  logic [NUM_SLV-1:0]   s_ready;

  modport slave (
    input  cpu_status, cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, s_rdata, s_ready,
    output cpu_rdata, cpu_ack, s_addr, s_wdata, s_wr_en, s_rd_en
  );

  modport master (
    output cpu_status, cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, s_rdata, s_ready,
    input  cpu_rdata, cpu_ack, s_addr, s_wdata, s_wr_en, s_rd_en
  );
endinterface

// File: rtl/peri_bus_fabric.sv
// Peripheral bus fabric: internal RAM window, BASE/MASK decoded slave slots with wait
// states and timeout, and an error status/address register pair.
module peri_bus_fabric #(
  parameter int unsigned            NUM_SLV   = 2,
  parameter logic [8*NUM_SLV-1:0]   SLV_BASE  = {8'h84, 8'h80},
  parameter logic [8*NUM_SLV-1:0]   SLV_MASK  = {8'hFC, 8'hFC},
  parameter int unsigned            RAM_DEPTH = 128,
  parameter int unsigned            TIMEOUT   = 15,
  parameter logic [7:0]             ERR_ADDR  = 8'hFF
) (
  input logic             clk,
  input logic             reset_n,
  peri_bus_fabric_if.slave bus
);
  localparam int unsigned AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [8:0]  RAM_TOP   = 9'(RAM_DEPTH);
  localparam logic [7:0]  ERR_ADDR1 = ERR_ADDR - 8'd1;
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RAM, S_STROBE, S_WAIT, S_ERRACC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         addr_q, wdata_q, rdata_q, cnt_q, err_addr_q;
  logic               wr_q;
  logic [1:0]         err_stat_q;
  logic [NUM_SLV-1:0] sel_q, hit;
  logic               hit_any, req, is_ram, is_err, slv_ready;
  logic [7:0]         slv_rdata;
  logic [7:0]         mem [RAM_DEPTH];

  assign req    = bus.cpu_rd_en | bus.cpu_wr_en;
  assign is_ram = {1'b0, bus.cpu_addr} < RAM_TOP;
  assign is_err = (bus.cpu_addr == ERR_ADDR) || (bus.cpu_addr == ERR_ADDR1);

  // Lowest-index matching slot wins when regions overlap
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!hit_any && ((bus.cpu_addr & SLV_MASK[8*i +: 8]) == SLV_BASE[8*i +: 8])) begin
        hit[i]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    slv_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) slv_rdata = slv_rdata | bus.s_rdata[8*i +: 8];
    end
    slv_ready = |(bus.s_ready & sel_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) begin
                  if (is_ram)       state_d = S_RAM;
                  else if (is_err)  state_d = S_ERRACC;
                  else if (hit_any) state_d = S_STROBE;
                  else              state_d = S_ERRACC;
                end
      S_RAM:    state_d = S_DONE;
      S_STROBE: state_d = slv_ready ? S_DONE : S_WAIT;
      S_WAIT:   if (slv_ready || cnt_q == TO_LAST) state_d = S_DONE;
      S_ERRACC: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_ack   = (state_q == S_DONE);
    bus.cpu_rdata = rdata_q;
    bus.s_addr    = addr_q;
    bus.s_wdata   = wdata_q;
    bus.s_wr_en   = '0;
    bus.s_rd_en   = '0;
    if (state_q == S_STROBE) begin
      if (wr_q) bus.s_wr_en = sel_q;
      else      bus.s_rd_en = sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_addr_q <= '0;
      err_stat_q <= '0;
      wr_q       <= 1'b0;
      sel_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
          wr_q    <= bus.cpu_wr_en;
          sel_q   <= hit;
          cnt_q   <= '0;
        end
        S_RAM:    rdata_q <= wr_q ? 8'h00 : mem[addr_q[AW-1:0]];
        S_STROBE: begin
          cnt_q <= '0;
          if (slv_ready) rdata_q <= wr_q ? 8'h00 : slv_rdata;
        end
        S_WAIT: begin
          if (slv_ready) begin
            rdata_q <= wr_q ? 8'h00 : slv_rdata;
          end else if (cnt_q == TO_LAST) begin
            rdata_q       <= wr_q ? 8'h00 : 8'hEE;
            err_stat_q[0] <= 1'b1;
            err_addr_q    <= addr_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_ERRACC: begin
          if (addr_q == ERR_ADDR) begin
            rdata_q <= wr_q ? 8'h00 : {6'b0, err_stat_q};
            if (wr_q) err_stat_q <= err_stat_q & ~wdata_q[1:0];
          end else if (addr_q == ERR_ADDR1) begin
            rdata_q <= wr_q ? 8'h00 : err_addr_q;
          end else begin
            rdata_q       <= 8'h00;
            err_stat_q[1] <= 1'b1;
            err_addr_q    <= addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write lands on the latch edge so the following RAM cycle can already read it back
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req && is_ram && bus.cpu_wr_en && bus.cpu_addr != 8'h00)
      mem[bus.cpu_addr[AW-1:0]] <= bus.cpu_wdata;
    mem[0] <= bus.cpu_status;
  end
endmodule
